// File: rtl/rmii_rx_stream_if.sv
// Received-frame word stream from the RMII front end to the packet parser.
// There is no backpressure, so every beat is a one-cycle rx_vld pulse.
interface rmii_rx_stream_if #(
  parameter int W_BYTES = 1
);
  logic                 rx_vld;
  logic                 rx_last;
  logic                 rx_err;
  logic [W_BYTES-1:0]   rx_keep;
  logic [8*W_BYTES-1:0] rx_data;

  modport master (output rx_vld, rx_last, rx_err, rx_keep, rx_data);
  modport slave  (input  rx_vld, rx_last, rx_err, rx_keep, rx_data);
endinterface

// File: rtl/rmii_rx_stream.sv
// RMII 100M receive front end: drives the ref clock, strips preamble/SFD and packs bytes into words.
// Define RMII_RX_FCS_CHECK_EN to flag frames whose CRC-32 residue is wrong.
module rmii_rx_stream #(
  parameter int CLK_DIV = 2,
  parameter int W_BYTES = 1
) (
  input  logic              clk,
  input  logic              reset,
  rmii_rx_stream_if.master  rx,
  output logic              eth_resetn,
  output logic              eth_clk,
  output logic [1:0]        eth_txd,
  output logic              eth_tx_en,
  input  logic [1:0]        eth_rxd,
  input  logic              eth_rx_err,
  input  logic              eth_crs_dv
);
  localparam int HALF = CLK_DIV / 2;
  localparam int CW   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int BW   = $clog2(W_BYTES + 1);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DISCARD} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        div_cnt, div_nxt;
  logic                 stb;
  logic [1:0]           s_rxd;
  logic                 s_dv, s_err;
  logic                 seen01, low1;
  logic [1:0]           pend;
  logic                 pend_vld, tent;
  logic [7:0]           shreg, byte_val;
  logic [1:0]           dcnt;
  logic [BW-1:0]        bcnt;
  logic [8*W_BYTES-1:0] wbuf, wbuf_ins, hold;
  logic [W_BYTES-1:0]   keep_part;
  logic                 hold_vld, perr, any_byte;
  logic                 start, commit, frame_end, byte_done, frame_err, fcs_bad;

  assign eth_resetn = ~reset;
  assign eth_txd    = 2'b00;
  assign eth_tx_en  = 1'b0;

  // Pins are captured on the edge where eth_clk rises; the FSM steps one cycle later on stb.
  always_comb div_nxt = (div_cnt == CW'(CLK_DIV - 1)) ? '0 : div_cnt + CW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      eth_clk <= 1'b0;
      stb     <= 1'b0;
      s_rxd   <= 2'b00;
      s_dv    <= 1'b0;
      s_err   <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      eth_clk <= (div_nxt >= CW'(HALF));
      stb     <= (div_cnt == CW'(HALF - 1));
      if (div_cnt == CW'(HALF - 1)) begin
        s_rxd <= eth_rxd;
        s_dv  <= eth_crs_dv;
        s_err <= eth_rx_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (stb) begin
      case (state)
        IDLE:     if (s_dv) state_nxt = PREAMBLE;
        PREAMBLE: begin
          if (!s_dv)                 state_nxt = IDLE;
          else if (s_rxd == 2'b11)   state_nxt = seen01 ? DATA : DISCARD;
          else if (s_rxd == 2'b10)   state_nxt = DISCARD;
        end
        DATA:     if (!s_dv && tent) state_nxt = IDLE;
        DISCARD:  if (!s_dv && low1) state_nxt = IDLE;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  // Each dibit is held one strobe in pend so a low-CRS_DV dibit can be dropped if the frame ends.
  always_comb begin
    start     = stb && (state == PREAMBLE) && (state_nxt == DATA);
    frame_end = stb && (state == DATA) && !s_dv && tent;
    commit    = stb && (state == DATA) && pend_vld && !frame_end;
    byte_val  = {pend, shreg[7:2]};
    byte_done = commit && (dcnt == 2'd3);
    wbuf_ins  = wbuf;
    keep_part = '0;
    for (int i = 0; i < W_BYTES; i++) begin
      if (BW'(i) == bcnt) wbuf_ins[i*8 +: 8] = byte_val;
      keep_part[i] = (BW'(i) < bcnt);
    end
    frame_err = perr | s_err | (dcnt != 2'd0) | ~any_byte | fcs_bad;
  end

`ifdef RMII_RX_FCS_CHECK_EN
  logic [31:0] crc, crc_nxt;

  always_comb begin
    crc_nxt = crc;
    for (int i = 0; i < 2; i++)
      crc_nxt = (crc_nxt >> 1) ^ ((crc_nxt[0] ^ pend[i]) ? 32'hEDB88320 : 32'h0);
    fcs_bad = (crc != 32'hDEBB20E3);
  end

  always_ff @(posedge clk) begin
    if (reset || start) crc <= 32'hFFFFFFFF;
    else if (commit)    crc <= crc_nxt;
  end
`else
  assign fcs_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      rx.rx_vld  <= 1'b0;
      rx.rx_last <= 1'b0;
      rx.rx_err  <= 1'b0;
      rx.rx_keep <= '0;
      rx.rx_data <= '0;
      seen01     <= 1'b0;
      low1       <= 1'b0;
      pend       <= 2'b00;
      pend_vld   <= 1'b0;
      tent       <= 1'b0;
      shreg      <= '0;
      dcnt       <= 2'd0;
      bcnt       <= '0;
      wbuf       <= '0;
      hold       <= '0;
      hold_vld   <= 1'b0;
      perr       <= 1'b0;
      any_byte   <= 1'b0;
    end else begin
      rx.rx_vld  <= 1'b0;
      rx.rx_last <= 1'b0;
      rx.rx_err  <= 1'b0;
      rx.rx_keep <= '0;
      rx.rx_data <= '0;
      if (stb) begin
        if (state == IDLE) seen01 <= 1'b0;
        else if (state == PREAMBLE && s_rxd == 2'b01) seen01 <= 1'b1;
        low1 <= (state == DISCARD) && !s_dv;
      end
      if (start) begin
        pend_vld <= 1'b0;
        tent     <= 1'b0;
        dcnt     <= 2'd0;
        bcnt     <= '0;
        wbuf     <= '0;
        hold_vld <= 1'b0;
        perr     <= 1'b0;
        any_byte <= 1'b0;
      end
      if (stb && state == DATA) begin
        if (s_err) perr <= 1'b1;
        if (!frame_end) begin
          pend     <= s_rxd;
          pend_vld <= 1'b1;
          tent     <= !s_dv;
        end
      end
      if (commit) begin
        shreg <= byte_val;
        dcnt  <= dcnt + 2'd1;
      end
      if (byte_done && hold_vld) begin
        rx.rx_vld  <= 1'b1;
        rx.rx_keep <= '1;
        rx.rx_data <= hold;
        hold_vld   <= 1'b0;
      end
      if (byte_done) begin
        any_byte <= 1'b1;
        if (bcnt == BW'(W_BYTES - 1)) begin
          hold     <= wbuf_ins;
          hold_vld <= 1'b1;
          bcnt     <= '0;
          wbuf     <= '0;
        end else begin
          wbuf <= wbuf_ins;
          bcnt <= bcnt + BW'(1);
        end
      end
      if (frame_end) begin
        rx.rx_vld  <= 1'b1;
        rx.rx_last <= 1'b1;
        rx.rx_err  <= frame_err;
        rx.rx_keep <= hold_vld ? '1 : keep_part;
        rx.rx_data <= hold_vld ? hold : wbuf;
        hold_vld   <= 1'b0;
      end
    end
  end
endmodule
